// File: rtl/vip_ycbcr_skin_bbox_pkg.sv
// Shared definitions for the YCbCr skin classifier and bounding-box tracker.
//   - bbox_state_e : frame accumulator FSM encoding (IDLE=0, ACTIVE=1, LATCH=2)
//   - SKIN_*       : default Cb/Cr skin window (inclusive bounds)
//   - in_range()   : unsigned 8-bit inclusive window test
package vip_ycbcr_skin_bbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LATCH  = 2'd2
  } bbox_state_e;

  localparam int unsigned SKIN_CB_MIN = 77;
  localparam int unsigned SKIN_CB_MAX = 127;
  localparam int unsigned SKIN_CR_MIN = 133;
  localparam int unsigned SKIN_CR_MAX = 173;
  localparam int unsigned CNT_BITS    = 20;

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vip_ycbcr_skin_bbox_if.sv
// Pixel-stream and frame-result bundle for vip_ycbcr_skin_bbox.
//   master : pixel source side (drives per_img_*/data_en_i, observes results)
//   slave  : classifier side (consumes the stream, drives post_img_*/bbox_*)
interface vip_ycbcr_skin_bbox_if #(
  parameter int unsigned X_BITS = 11,
  parameter int unsigned Y_BITS = 10
);
  logic              per_img_vsync;
  logic              per_img_href;
  logic [7:0]        per_img_Y;
  logic [7:0]        per_img_Cb;
  logic [7:0]        per_img_Cr;
  logic              data_en_i;

  logic              post_img_vsync;
  logic              post_img_href;
  logic              data_en_o;
  logic              post_img_bit;

  logic              bbox_valid;
  logic              bbox_found;
  logic [X_BITS-1:0] bbox_x_min;
  logic [X_BITS-1:0] bbox_x_max;
  logic [Y_BITS-1:0] bbox_y_min;
  logic [Y_BITS-1:0] bbox_y_max;
  logic [19:0]       skin_count;

  modport master (
    output per_img_vsync, per_img_href, per_img_Y, per_img_Cb, per_img_Cr, data_en_i,
    input  post_img_vsync, post_img_href, data_en_o, post_img_bit,
    input  bbox_valid, bbox_found, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, skin_count
  );

  modport slave (
    input  per_img_vsync, per_img_href, per_img_Y, per_img_Cb, per_img_Cr, data_en_i,
    output post_img_vsync, post_img_href, data_en_o, post_img_bit,
    output bbox_valid, bbox_found, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, skin_count
  );
endinterface

// File: rtl/vip_frame_bbox_acc.sv
// Per-frame skin statistics: column/row counters, skin count, bounding box,
// and the once-per-frame result latch.
//   clk, rst_n     : clock, synchronous active-low reset
//   vs_rise_i      : frame boundary (vsync rising edge on the input)
//   href_fall_i    : end of an input line
//   pix_valid_i    : qualified pixel this cycle (already excludes vs_rise)
//   pix_skin_i     : classifier result for this pixel
//   bbox_valid_o   : 1-cycle pulse when results below update
//   bbox_found_o, bbox_*_o, skin_count_o : last completed frame results
module vip_frame_bbox_acc
  import vip_ycbcr_skin_bbox_pkg::*;
#(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned X_BITS     = 11,
  parameter int unsigned Y_BITS     = 10,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_rise_i,
  input  logic              href_fall_i,
  input  logic              pix_valid_i,
  input  logic              pix_skin_i,
  output logic              bbox_valid_o,
  output logic              bbox_found_o,
  output logic [X_BITS-1:0] bbox_x_min_o,
  output logic [X_BITS-1:0] bbox_x_max_o,
  output logic [Y_BITS-1:0] bbox_y_min_o,
  output logic [Y_BITS-1:0] bbox_y_max_o,
  output logic [19:0]       skin_count_o
);

  bbox_state_e       state_q;
  logic [X_BITS-1:0] col_q, col_d;
  logic [Y_BITS-1:0] row_q, row_d;
  logic              any_q, any_d;
  logic [19:0]       cnt_q, cnt_d;
  logic [X_BITS-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_BITS-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic              stats_pix;
  logic              fresh;

  logic              bv_q, found_q;
  logic [X_BITS-1:0] oxmin_q, oxmax_q;
  logic [Y_BITS-1:0] oymin_q, oymax_q;
  logic [19:0]       ocnt_q;

  always_comb begin
    col_d = col_q;
    if (href_fall_i)                                     col_d = '0;
    else if (pix_valid_i && (col_q < X_BITS'(IMG_W)))    col_d = col_q + X_BITS'(1);
    row_d = row_q;
    if (vs_rise_i)                                       row_d = '0;
    else if (href_fall_i && (row_q < Y_BITS'(IMG_H)))    row_d = row_q + Y_BITS'(1);
  end

  assign stats_pix = pix_valid_i && pix_skin_i &&
                     (col_q < X_BITS'(IMG_W)) && (row_q < Y_BITS'(IMG_H));

  // In LATCH the accumulators restart from empty, yet a pixel arriving in
  // that same cycle must still be folded in as the new frame's first sample.
  always_comb begin
    fresh  = (state_q == ST_LATCH);
    any_d  = fresh ? 1'b0 : any_q;
    cnt_d  = fresh ? '0   : cnt_q;
    xmin_d = fresh ? '0   : xmin_q;
    xmax_d = fresh ? '0   : xmax_q;
    ymin_d = fresh ? '0   : ymin_q;
    ymax_d = fresh ? '0   : ymax_q;
    if (stats_pix) begin
      if (cnt_d != '1) cnt_d = cnt_d + 20'd1;
      if (!any_d) begin
        xmin_d = col_q; xmax_d = col_q;
        ymin_d = row_q; ymax_d = row_q;
      end else begin
        if (col_q < xmin_d) xmin_d = col_q;
        if (col_q > xmax_d) xmax_d = col_q;
        if (row_q < ymin_d) ymin_d = row_q;
        if (row_q > ymax_d) ymax_d = row_q;
      end
      any_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q <= '0;   row_q <= '0;
      any_q <= 1'b0; cnt_q <= '0;
      xmin_q <= '0;  xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
      bv_q <= 1'b0;  found_q <= 1'b0;
      oxmin_q <= '0; oxmax_q <= '0; oymin_q <= '0; oymax_q <= '0;
      ocnt_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      bv_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Partial frame before the first boundary is never reported.
          if (vs_rise_i) begin
            any_q <= 1'b0; cnt_q <= '0;
            xmin_q <= '0;  xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // At vs_rise the pixel is excluded, so the _d values equal the
          // completed frame and the latch below can read the _q values.
          any_q <= any_d;   cnt_q <= cnt_d;
          xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
          if (vs_rise_i) begin
            bv_q    <= 1'b1;
            found_q <= any_q && (cnt_q >= CNT_BITS'(MIN_PIXELS));
            oxmin_q <= any_q ? xmin_q : '0;
            oxmax_q <= any_q ? xmax_q : '0;
            oymin_q <= any_q ? ymin_q : '0;
            oymax_q <= any_q ? ymax_q : '0;
            ocnt_q  <= cnt_q;
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          any_q <= any_d;   cnt_q <= cnt_d;
          xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
          state_q <= ST_ACTIVE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bbox_valid_o = bv_q;
  assign bbox_found_o = found_q;
  assign bbox_x_min_o = oxmin_q;
  assign bbox_x_max_o = oxmax_q;
  assign bbox_y_min_o = oymin_q;
  assign bbox_y_max_o = oymax_q;
  assign skin_count_o = ocnt_q;

endmodule

// File: rtl/vip_ycbcr_skin_bbox.sv
// Skin classifier on a YCbCr444 stream with per-frame bounding box.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   bus        : slave side of vip_ycbcr_skin_bbox_if
//                in : per_img_vsync/href/Y/Cb/Cr, data_en_i
//                out: post_img_vsync/href, data_en_o, post_img_bit (1 clk late)
//                     bbox_valid pulse + bbox_found/x/y/skin_count of last frame
module vip_ycbcr_skin_bbox
  import vip_ycbcr_skin_bbox_pkg::*;
#(
  parameter int unsigned CB_MIN     = SKIN_CB_MIN,
  parameter int unsigned CB_MAX     = SKIN_CB_MAX,
  parameter int unsigned CR_MIN     = SKIN_CR_MIN,
  parameter int unsigned CR_MAX     = SKIN_CR_MAX,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned X_BITS     = 11,
  parameter int unsigned Y_BITS     = 10,
  parameter int unsigned MIN_PIXELS = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  vip_ycbcr_skin_bbox_if.slave bus
);

  logic vsync_q, href_q, de_q, bit_q;
  logic skin_c, vs_rise, href_fall, pix_valid;
  logic unused_y;

  // Luma does not take part in the skin decision.
  assign unused_y = ^bus.per_img_Y;

  assign skin_c = in_range(bus.per_img_Cb, 8'(CB_MIN), 8'(CB_MAX)) &&
                  in_range(bus.per_img_Cr, 8'(CR_MIN), 8'(CR_MAX));

  // The delayed vsync/href double as the edge-detect history.
  assign vs_rise   = bus.per_img_vsync && !vsync_q;
  assign href_fall = href_q && !bus.per_img_href;
  assign pix_valid = bus.per_img_href && bus.data_en_i && !vs_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      de_q    <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      vsync_q <= bus.per_img_vsync;
      href_q  <= bus.per_img_href;
      de_q    <= bus.data_en_i;
      bit_q   <= skin_c && bus.per_img_href;
    end
  end

  assign bus.post_img_vsync = vsync_q;
  assign bus.post_img_href  = href_q;
  assign bus.data_en_o      = de_q;
  assign bus.post_img_bit   = bit_q;

  vip_frame_bbox_acc #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_BITS(X_BITS), .Y_BITS(Y_BITS), .MIN_PIXELS(MIN_PIXELS)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs_rise_i   (vs_rise),
    .href_fall_i (href_fall),
    .pix_valid_i (pix_valid),
    .pix_skin_i  (skin_c),
    .bbox_valid_o(bus.bbox_valid),
    .bbox_found_o(bus.bbox_found),
    .bbox_x_min_o(bus.bbox_x_min),
    .bbox_x_max_o(bus.bbox_x_max),
    .bbox_y_min_o(bus.bbox_y_min),
    .bbox_y_max_o(bus.bbox_y_max),
    .skin_count_o(bus.skin_count)
  );

endmodule
